doc_writer: RTL and testbench

- Editing front-end that fills the 20x15 character document RAM read by the text display stage.
- Accepts one character or control code per handshake and writes it into the document RAM write port.
- Maintains a text cursor (row/column) and clears the whole document on reset or on command.
- Display side reads the RAM asynchronously on its own port. This block owns the write port exclusively.

---
 rtl/doc_writer_if.sv | 22 ++
 rtl/doc_writer.sv | 143 ++++++++++++++
 tb/tb_doc_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/doc_writer_if.sv
// Key stream into the editor and write port out to the document RAM,
// plus cursor/busy status for the display side.
interface doc_writer_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic       doc_we;
  logic [8:0] doc_addr;
  logic [7:0] doc_din;
  logic [8:0] cursor;
  logic       busy;

  modport master (
    output key_valid, key_code,
    input  key_ready, doc_we, doc_addr, doc_din, cursor, busy
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, doc_we, doc_addr, doc_din, cursor, busy
  );
endinterface

// File: rtl/doc_writer.sv
// Editing front-end: consumes key codes, writes the character document RAM,
// tracks the text cursor and sweeps the whole document with FILL_CHAR on clear.
module doc_writer #(
  parameter int         COLS      = 20,
  parameter int         ROWS      = 15,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  doc_writer_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [8:0]    r_clr_addr;
  logic [8:0]    r_cursor;
  logic          r_doc_we;
  logic [8:0]    r_doc_addr;
  logic [7:0]    r_doc_din;
  logic          r_key_ready;
  logic          r_busy;

  logic [CW-1:0] w_col_n;
  logic [RW-1:0] w_row_n;
  logic          w_wr;
  logic [8:0]    w_waddr;
  logic [7:0]    w_wdata;
  logic          w_ff;

  function automatic logic [8:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return 9'(row) * 9'(COLS) + 9'(col);
  endfunction

  // Key decode: next cursor position and the write (if any) this key causes
  always_comb begin
    w_col_n = r_col;
    w_row_n = r_row;
    w_wr    = 1'b0;
    w_waddr = r_cursor;
    w_wdata = bus.key_code;
    w_ff    = 1'b0;
    if (r_state == S_IDLE && bus.key_valid) begin
      if (bus.key_code >= 8'h20 && bus.key_code <= 8'h7E) begin
        w_wr = 1'b1;
        if (r_col != CW'(COLS - 1)) begin
          w_col_n = r_col + CW'(1);
        end else if (r_row != RW'(ROWS - 1)) begin
          w_col_n = '0;
          w_row_n = r_row + RW'(1);
        end
      end else begin
        case (bus.key_code)
          8'h0D: begin
            if (r_row != RW'(ROWS - 1)) begin
              w_col_n = '0;
              w_row_n = r_row + RW'(1);
            end
          end
          8'h08: begin
            if (r_cursor != 9'd0) begin
              if (r_col == '0) begin
                w_col_n = CW'(COLS - 1);
                w_row_n = r_row - RW'(1);
              end else begin
                w_col_n = r_col - CW'(1);
              end
              w_wr    = 1'b1;
              w_wdata = FILL_CHAR;
              w_waddr = cell_addr(w_row_n, w_col_n);
            end
          end
          8'h0C:   w_ff = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_cursor    <= '0;
      r_doc_we    <= 1'b0;
      r_doc_addr  <= '0;
      r_doc_din   <= '0;
      r_key_ready <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          // clr_addr runs one past the last cell so the final write gets its own cycle
          if (r_clr_addr == 9'(CELLS)) begin
            r_doc_we    <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b1;
          end else begin
            r_doc_we   <= 1'b1;
            r_doc_addr <= r_clr_addr;
            r_doc_din  <= FILL_CHAR;
            r_clr_addr <= r_clr_addr + 9'd1;
          end
        end
        S_IDLE: begin
          r_doc_we <= w_wr;
          if (w_wr) begin
            r_doc_addr <= w_waddr;
            r_doc_din  <= w_wdata;
          end
          r_col    <= w_col_n;
          r_row    <= w_row_n;
          r_cursor <= cell_addr(w_row_n, w_col_n);
          if (w_ff) begin
            r_col       <= '0;
            r_row       <= '0;
            r_cursor    <= '0;
            r_clr_addr  <= '0;
            r_state     <= S_CLEAR;
            r_busy      <= 1'b1;
            r_key_ready <= 1'b0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign bus.key_ready = r_key_ready;
  assign bus.doc_we    = r_doc_we;
  assign bus.doc_addr  = r_doc_addr;
  assign bus.doc_din   = r_doc_din;
  assign bus.cursor    = r_cursor;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_doc_writer.sv
// Directed bench for doc_writer: key tables with hand-computed writes/cursor,
// plus sequences for clear sweeps, document end and reset during a clear.
module tb_doc_writer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   pass_cnt = 0;

  doc_writer_if bus ();

  doc_writer #(.COLS(20), .ROWS(15), .FILL_CHAR(8'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       we;
    logic [8:0] addr;
    logic [7:0] din;
    logic [8:0] cur;
  } vec_t;

  vec_t tab_a[3];
  vec_t tab_b[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Present one key at a negedge; its registered effect is checked at the next negedge
  task automatic send(input string nm, input logic [7:0] code, input logic we,
                      input logic [8:0] addr, input logic [7:0] din, input logic [8:0] cur);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    chk({nm, "_we"}, 32'(bus.doc_we), 32'(we));
    if (we) begin
      chk({nm, "_addr"}, 32'(bus.doc_addr), 32'(addr));
      chk({nm, "_din"}, 32'(bus.doc_din), 32'(din));
    end
    chk({nm, "_cursor"}, 32'(bus.cursor), 32'(cur));
  endtask

  task automatic check_clear(input string nm);
    int  n = 0;
    int  guard = 0;
    bit  ok = 1'b1;
    while (!bus.doc_we && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_busy_during"}, 32'(bus.busy), 32'd1);
    chk({nm, "_ready_during"}, 32'(bus.key_ready), 32'd0);
    while (bus.doc_we && n < 400) begin
      if (bus.doc_addr !== 9'(n) || bus.doc_din !== 8'h20) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    chk({nm, "_count"}, 32'(n), 32'd300);
    chk({nm, "_seq"}, 32'(ok), 32'd1);
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({nm, "_ready_after"}, 32'(bus.key_ready), 32'd1);
    chk({nm, "_cursor_after"}, 32'(bus.cursor), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    tab_a[0] = '{8'h08, 1'b0, 9'd0,  8'h00, 9'd0};
    tab_a[1] = '{8'h48, 1'b1, 9'd0,  8'h48, 9'd1};
    tab_a[2] = '{8'h69, 1'b1, 9'd1,  8'h69, 9'd2};

    tab_b[0] = '{8'h41, 1'b1, 9'd19, 8'h41, 9'd20};
    tab_b[1] = '{8'h08, 1'b1, 9'd19, 8'h20, 9'd19};
    tab_b[2] = '{8'h08, 1'b1, 9'd18, 8'h20, 9'd18};
    tab_b[3] = '{8'h0D, 1'b0, 9'd0,  8'h00, 9'd20};
    tab_b[4] = '{8'h07, 1'b0, 9'd0,  8'h00, 9'd20};
    tab_b[5] = '{8'hC3, 1'b0, 9'd0,  8'h00, 9'd20};
    tab_b[6] = '{8'h7F, 1'b0, 9'd0,  8'h00, 9'd20};
    tab_b[7] = '{8'h20, 1'b1, 9'd20, 8'h20, 9'd21};
    tab_b[8] = '{8'h08, 1'b1, 9'd20, 8'h20, 9'd20};
    tab_b[9] = '{8'h08, 1'b1, 9'd19, 8'h20, 9'd19};

    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(bus.doc_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_ready", 32'(bus.key_ready), 32'd0);
    chk("rst_cursor", 32'(bus.cursor), 32'd0);
    chk("rst_addr", 32'(bus.doc_addr), 32'd0);
    chk("rst_din", 32'(bus.doc_din), 32'd0);
    rst = 1'b1;
    check_clear("init");

    for (int i = 0; i < 3; i++)
      send($sformatf("tabA%0d", i), tab_a[i].code, tab_a[i].we, tab_a[i].addr, tab_a[i].din, tab_a[i].cur);
    for (int k = 0; k < 17; k++)
      send("fill_row0", 8'(8'h61 + k), 1'b1, 9'(2 + k), 8'(8'h61 + k), 9'(3 + k));
    for (int i = 0; i < 10; i++)
      send($sformatf("tabB%0d", i), tab_b[i].code, tab_b[i].we, tab_b[i].addr, tab_b[i].din, tab_b[i].cur);

    send("enter_to_20", 8'h0D, 1'b0, 9'd0, 8'h00, 9'd20);
    for (int k = 0; k < 25; k++)
      send("fill_to_45", 8'h2E, 1'b1, 9'(20 + k), 8'h2E, 9'(21 + k));
    send("enter_45", 8'h0D, 1'b0, 9'd0, 8'h00, 9'd60);
    for (int k = 0; k < 11; k++)
      send("enter_down", 8'h0D, 1'b0, 9'd0, 8'h00, 9'(80 + 20 * k));
    send("enter_last_row", 8'h0D, 1'b0, 9'd0, 8'h00, 9'd280);
    for (int k = 0; k < 19; k++)
      send("fill_row14", 8'h2D, 1'b1, 9'(280 + k), 8'h2D, 9'(281 + k));
    send("end_X", 8'h58, 1'b1, 9'd299, 8'h58, 9'd299);
    send("end_Y", 8'h59, 1'b1, 9'd299, 8'h59, 9'd299);

    send("ff", 8'h0C, 1'b0, 9'd0, 8'h00, 9'd0);
    chk("ff_busy", 32'(bus.busy), 32'd1);
    chk("ff_ready", 32'(bus.key_ready), 32'd0);
    bus.key_valid = 1'b0;
    check_clear("ff_clear");

    send("bell", 8'h07, 1'b0, 9'd0, 8'h00, 9'd0);
    send("hi_code", 8'hC3, 1'b0, 9'd0, 8'h00, 9'd0);

    send("ff2", 8'h0C, 1'b0, 9'd0, 8'h00, 9'd0);
    bus.key_valid = 1'b0;
    guard = 0;
    while (!(bus.doc_we && bus.doc_addr == 9'd150) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_150", 32'(bus.doc_addr), 32'd150);
    rst = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 8'h5A;
    @(negedge clk);
    chk("midrst_we", 32'(bus.doc_we), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd1);
    chk("midrst_ready", 32'(bus.key_ready), 32'd0);
    rst = 1'b1;
    check_clear("midrst_clear");

    send("after_Q", 8'h51, 1'b1, 9'd0, 8'h51, 9'd1);
    bus.key_valid = 1'b0;
    @(negedge clk);
    chk("idle_we_low", 32'(bus.doc_we), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
